// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types and helpers for the APB3 register-file completer.
//   apb_slv_state_t    : transfer FSM states
//   ID_REG_IDX         : index of the read-only ID register
//   APB_SLV_DEFAULT_ID : default constant returned by the ID register
//   addr_ok()          : word-aligned and inside the register window
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_slv_state_t;

  localparam int unsigned ID_REG_IDX         = 0;
  localparam logic [31:0] APB_SLV_DEFAULT_ID = 32'hA5B0_0001;

  // True when the byte address is word-aligned and maps onto an existing register.
  function automatic logic addr_ok(input logic [63:0] addr, input int unsigned num_regs);
    logic [63:0] limit;
    limit   = 64'(num_regs) << 2;
    addr_ok = (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter used to time APB wait states.
//   clk, rst_n  : clock, async active-low reset
//   i_clr       : force the count to zero (aborted transfer)
//   i_load      : load i_load_val (setup phase)
//   i_load_val  : wait-state count for the transfer
//   i_dec       : decrement while waiting (saturates at zero)
//   o_last_c    : combinational, high when the current wait cycle is the final one
module apb_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_cnt;

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer holding NUM_REGS 32-bit word registers.
// Register 0 is a read-only ID (ID_VALUE); the others are read/write.
// Optional wait states: define APB_SLV_WAIT_STATES_EN to insert WAIT_CYCLES
// wait states per transfer; otherwise every transfer is zero-wait.
//   PCLK, PRESETn : clock, async active-low reset
//   PSEL, PENABLE : APB select / access-phase strobe
//   PADDR, PWRITE : byte address and direction, latched in the setup phase
//   PWDATA        : write data, sampled at the completing edge
//   PRDATA        : read data (0 for writes and errors)
//   PREADY        : transfer completes this cycle
//   PSLVERR       : error response, meaningful with PREADY
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(APB_SLV_DEFAULT_ID)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_slv_state_t        r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_setup;
  logic                  w_viol;
  logic                  w_in_access;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_is_id;
  logic                  w_dec_err;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic [DATA_WIDTH-1:0] w_setup_rdata;

  // Address decode, evaluated in the setup phase and latched into r_idx/r_err.
  assign w_setup       = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_viol        = (r_state == IDLE) && PSEL && PENABLE;
  assign w_in_access   = (r_state == ACCESS) && PSEL;
  assign w_idx         = PADDR[IDX_W+1:2];
  assign w_is_id       = (w_idx == IDX_W'(ID_REG_IDX));
  assign w_dec_err     = !addr_ok(64'(PADDR), NUM_REGS) || (PWRITE && w_is_id);
  assign w_rd_val      = w_is_id ? ID_VALUE : r_regs[w_idx];
  assign w_setup_rdata = (PWRITE || w_dec_err) ? '0 : w_rd_val;

  // Response: ready in ACCESS while still selected, or immediately on a
  // missing setup phase, which is reported as an error.
  assign PREADY  = w_in_access || w_viol;
  assign PSLVERR = (w_in_access && r_err) || w_viol;
  assign PRDATA  = r_prdata;

`ifdef APB_SLV_WAIT_STATES_EN
  logic w_cnt_last;

  apb_wait_counter #(
    .CNT_W(4)
  ) u_wait_counter (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .i_clr      ((r_state != IDLE) && !PSEL),
    .i_load     (w_setup),
    .i_load_val (4'(WAIT_CYCLES)),
    .i_dec      (r_state == WAIT),
    .o_last_c   (w_cnt_last)
  );
`else
  logic w_unused_wait;
  assign w_unused_wait = ^4'(WAIT_CYCLES);
`endif

  // Transfer FSM and register array.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_prdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          // PRDATA is held at zero whenever no transfer is in flight.
          r_prdata <= '0;
          if (w_setup) begin
            r_idx    <= w_idx;
            r_err    <= w_dec_err;
            r_write  <= PWRITE;
            r_prdata <= w_setup_rdata;
`ifdef APB_SLV_WAIT_STATES_EN
            r_state  <= (WAIT_CYCLES != 0) ? WAIT : ACCESS;
`else
            r_state  <= ACCESS;
`endif
          end
        end
`ifdef APB_SLV_WAIT_STATES_EN
        WAIT: begin
          if (!PSEL) begin
            r_state  <= IDLE;
            r_prdata <= '0;
          end else if (w_cnt_last) begin
            r_state  <= ACCESS;
          end
        end
`endif
        ACCESS: begin
          if (!PSEL) begin
            r_state  <= IDLE;
            r_prdata <= '0;
          end else if (PENABLE) begin
            r_state  <= IDLE;
            r_prdata <= '0;
            if (r_write && !r_err) begin
              r_regs[r_idx] <= PWDATA;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_prdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: randomized APB transfers against an array-based model,
// plus directed transfers with literal expectations.
module tb_apb_slave_regfile;

  localparam int unsigned NR = 8;
  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_STATES_EN
  localparam int unsigned WAITS   = 2;
  localparam int unsigned EXP_CYC = 4;
`else
  localparam int unsigned WAITS   = 0;
  localparam int unsigned EXP_CYC = 2;
`endif

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_slave_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (NR),
    .WAIT_CYCLES(2),
    .ID_VALUE   (ID)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc_cnt = 0;
  logic [31:0] mregs [NR];
  logic        chk_en    = 1'b0;
  logic        exp_ready = 1'b0;
  logic        exp_err   = 1'b0;
  logic [31:0] exp_rdata = '0;

  always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

  // Reference rules for a transfer, straight from the address map.
  function automatic logic m_err(input logic [31:0] a, input logic w);
    return (a[1:0] != 2'b00) || (a >= 32'(NR * 4)) || (w && (a == 32'h0));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic w);
    if (w || m_err(a, w)) return 32'h0;
    if (a == 32'h0) return ID;
    return mregs[a[4:2]];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Per-cycle compare of the response against the model's expectation.
  always @(negedge PCLK) begin
    if (chk_en) begin
      checks++;
      if (PREADY !== exp_ready) begin
        errors++;
        $display("FAIL pready at %0t: got=%b expected=%b", $time, PREADY, exp_ready);
      end
      if (exp_ready) begin
        checks++;
        if (PSLVERR !== exp_err) begin
          errors++;
          $display("FAIL pslverr at %0t: got=%b expected=%b", $time, PSLVERR, exp_err);
        end
        checks++;
        if (PRDATA !== exp_rdata) begin
          errors++;
          $display("FAIL prdata at %0t: got=%h expected=%h", $time, PRDATA, exp_rdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; exp_ready = 1'b0;
    end
  endtask

  // mode 0: normal, 1: drop PSEL in the first access-phase cycle,
  // 2: scramble PADDR/PWRITE/PWDATA during the access phase.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int mode,
                      output logic [31:0] rd, output logic err, output int ncyc);
    logic [31:0] e_rd;
    logic        e_err;
    logic [31:0] dl;
    bit          seen;
    e_err = m_err(a, w);
    e_rd  = m_read(a, w);
    dl    = d;
    seen  = 0;
    rd    = '0;
    err   = 1'b0;
    ncyc  = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; exp_ready = 1'b0;
    @(negedge PCLK);
    for (int k = 0; k <= int'(WAITS); k++) begin
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      if (mode == 1) begin
        PSEL = 1'b0; PENABLE = 1'b0; exp_ready = 1'b0;
      end else begin
        exp_ready = (k == int'(WAITS));
        exp_err   = e_err;
        exp_rdata = e_rd;
        if (mode == 2) begin
          PADDR  = $urandom;
          PWRITE = 1'($urandom_range(0, 1));
          dl     = $urandom;
          PWDATA = dl;
        end
      end
      @(negedge PCLK);
      if (PREADY && !seen) begin
        seen = 1; rd = PRDATA; err = PSLVERR; ncyc = k + 2;
      end
      if (mode == 1) break;
    end
    if (mode != 1 && w && !e_err) mregs[a[4:2]] = dl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          n;
    int          t0;
    logic [31:0] a;
    logic        w;
    int          mode;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    PADDR = '0; PWRITE = 1'b0; PWDATA = '0;
    for (int i = 0; i < int'(NR); i++) mregs[i] = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", 32'(PREADY), 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; chk_en = 1'b1;

    // ID and initial scratch contents.
    xfer(32'h00, 1'b0, 32'h0, 0, rd, err, n);
    check("id_read", rd, 32'hA5B0_0001);
    check("id_err", 32'(err), 32'h0);
    check("xfer_cycles", 32'(n), 32'(EXP_CYC));
    xfer(32'h04, 1'b0, 32'h0, 0, rd, err, n);
    check("reg1_reset", rd, 32'h0);

    // Write followed by read of the same register.
    xfer(32'h04, 1'b1, 32'hDEAD_BEEF, 0, rd, err, n);
    check("wr_cycles", 32'(n), 32'(EXP_CYC));
    xfer(32'h04, 1'b0, 32'h0, 0, rd, err, n);
    check("reg1_readback", rd, 32'hDEAD_BEEF);

    // ID register is read-only.
    xfer(32'h00, 1'b1, 32'h1234_5678, 0, rd, err, n);
    check("id_write_err", 32'(err), 32'h1);
    xfer(32'h00, 1'b0, 32'h0, 0, rd, err, n);
    check("id_after_write", rd, 32'hA5B0_0001);

    // Out-of-range and misaligned.
    xfer(32'h20, 1'b0, 32'h0, 0, rd, err, n);
    check("oor_err", 32'(err), 32'h1);
    check("oor_data", rd, 32'h0);
    xfer(32'h06, 1'b0, 32'h0, 0, rd, err, n);
    check("mis_err", 32'(err), 32'h1);
    check("mis_data", rd, 32'h0);

    // Back-to-back transfers with no idle cycles in between.
    t0 = cyc_cnt;
    xfer(32'h08, 1'b1, 32'h1, 0, rd, err, n);
    xfer(32'h0C, 1'b1, 32'h2, 0, rd, err, n);
    xfer(32'h08, 1'b0, 32'h0, 0, rd, err, n);
    check("b2b_rd8", rd, 32'h1);
    xfer(32'h0C, 1'b0, 32'h0, 0, rd, err, n);
    check("b2b_rdC", rd, 32'h2);
    check("b2b_cycles", 32'(cyc_cnt - t0), 32'(4 * EXP_CYC));

    // Missing setup phase: immediate error, no write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h08; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF;
    exp_ready = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
    @(negedge PCLK);
    check("viol_err", 32'(PSLVERR), 32'h1);
    idle(1);
    xfer(32'h08, 1'b0, 32'h0, 0, rd, err, n);
    check("viol_nowrite", rd, 32'h1);

    // PSEL dropped mid-transfer: no write.
    xfer(32'h10, 1'b1, 32'hCAFE_F00D, 1, rd, err, n);
    idle(1);
    xfer(32'h10, 1'b0, 32'h0, 0, rd, err, n);
    check("abort_nowrite", rd, 32'h0);

    // Reset during a pending write.
    xfer(32'h14, 1'b1, 32'h55, 0, rd, err, n);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h10; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D;
    exp_ready = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < int'(NR); i++) mregs[i] = '0;
    idle(2);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer(32'h10, 1'b0, 32'h0, 0, rd, err, n);
    check("rst_lost_write", rd, 32'h0);
    xfer(32'h14, 1'b0, 32'h0, 0, rd, err, n);
    check("rst_cleared", rd, 32'h0);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = {27'h0, 3'($urandom_range(0, NR - 1)), 2'b00};
        6, 7:             a = 32'($urandom_range(0, 63));
        default:          a = $urandom;
      endcase
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mode = 1;
      else if ($urandom_range(0, 3) == 0) mode = 2;
      else mode = 0;
      xfer(a, w, $urandom, mode, rd, err, n);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
